// File: rtl/lutram_fifo_pkg.sv
// Shared sizes and types for the 64x7 distributed-RAM FIFO.
package lutram_fifo_pkg;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 7;
    localparam int unsigned CW    = 7;

    typedef logic [DW-1:0] word_t;
    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
endpackage

// File: rtl/lutram_fifo64x7_if.sv
// Write/read handshake and status bundle of the 64x7 FIFO.
interface lutram_fifo64x7_if;
    import lutram_fifo_pkg::*;

    logic  wr_en;
    word_t din;
    logic  rd_en;
    word_t dout;
    logic  dvalid;
    logic  full;
    logic  empty;
    logic  almost_full;
    logic  almost_empty;
    cnt_t  count;
    logic  overflow;
    logic  underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, dvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, dvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/RAM64M8.sv
// Behavioural RAM64M8: 64x8 distributed RAM, one write port (H address), asynchronous reads.
module RAM64M8 #(
    parameter bit IS_WCLK_INVERTED = 1'b0
) (
    output logic       DOA, DOB, DOC, DOD, DOE, DOF, DOG, DOH,
    input  logic       DIA, DIB, DIC, DID, DIE, DIF, DIG, DIH,
    input  logic [5:0] ADDRA, ADDRB, ADDRC, ADDRD, ADDRE, ADDRF, ADDRG, ADDRH,
    input  logic       WE,
    input  logic       WCLK
);
    logic [7:0] mem [64];
    logic       wclk_c;

    assign wclk_c = WCLK ^ IS_WCLK_INVERTED;

    // Every bit column is written at the port H address.
    always_ff @(posedge wclk_c) begin
        if (WE) mem[ADDRH] <= {DIH, DIG, DIF, DIE, DID, DIC, DIB, DIA};
    end

    assign DOA = mem[ADDRA][0];
    assign DOB = mem[ADDRB][1];
    assign DOC = mem[ADDRC][2];
    assign DOD = mem[ADDRD][3];
    assign DOE = mem[ADDRE][4];
    assign DOF = mem[ADDRF][5];
    assign DOG = mem[ADDRG][6];
    assign DOH = mem[ADDRH][7];
endmodule

// File: rtl/lutram_fifo64x7.sv
// 64-deep x 7-bit FIFO controller around a single RAM64M8; registered data and flags.
module lutram_fifo64x7
    import lutram_fifo_pkg::*;
#(
    parameter int unsigned ALMOST_FULL_THRESH  = 56,
    parameter int unsigned ALMOST_EMPTY_THRESH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    lutram_fifo64x7_if.slave bus
);
    ptr_t  wr_ptr;
    ptr_t  rd_ptr;
    logic  wr_acc_c;
    logic  rd_acc_c;
    cnt_t  count_nxt_c;
    word_t ram_rd_c;
    logic  doh_unused;

    // Acceptance uses registered flags only, so RD_EN never gates a write combinationally.
    always_comb begin
        wr_acc_c    = bus.wr_en & ~bus.full;
        rd_acc_c    = bus.rd_en & ~bus.empty;
        count_nxt_c = bus.count;
        if (wr_acc_c && !rd_acc_c)      count_nxt_c = bus.count + CW'(1);
        else if (rd_acc_c && !wr_acc_c) count_nxt_c = bus.count - CW'(1);
    end

    RAM64M8 #(
        .IS_WCLK_INVERTED(1'b0)
    ) u_ram (
        .DOA(ram_rd_c[0]), .DOB(ram_rd_c[1]), .DOC(ram_rd_c[2]), .DOD(ram_rd_c[3]),
        .DOE(ram_rd_c[4]), .DOF(ram_rd_c[5]), .DOG(ram_rd_c[6]), .DOH(doh_unused),
        .DIA(bus.din[0]),  .DIB(bus.din[1]),  .DIC(bus.din[2]),  .DID(bus.din[3]),
        .DIE(bus.din[4]),  .DIF(bus.din[5]),  .DIG(bus.din[6]),  .DIH(1'b0),
        .ADDRA(rd_ptr), .ADDRB(rd_ptr), .ADDRC(rd_ptr), .ADDRD(rd_ptr),
        .ADDRE(rd_ptr), .ADDRF(rd_ptr), .ADDRG(rd_ptr), .ADDRH(wr_ptr),
        .WE(wr_acc_c),
        .WCLK(CLK)
    );

    // Flags are derived from the next count so they line up with COUNT.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            bus.count        <= '0;
            bus.dout         <= '0;
            bus.dvalid       <= 1'b0;
            bus.overflow     <= 1'b0;
            bus.underflow    <= 1'b0;
            bus.full         <= 1'b0;
            bus.empty        <= 1'b1;
            bus.almost_full  <= 1'b0;
            bus.almost_empty <= 1'b1;
        end else begin
            if (wr_acc_c) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc_c) begin
                rd_ptr   <= rd_ptr + AW'(1);
                bus.dout <= ram_rd_c;
            end
            bus.dvalid       <= rd_acc_c;
            bus.overflow     <= bus.wr_en & bus.full;
            bus.underflow    <= bus.rd_en & bus.empty;
            bus.count        <= count_nxt_c;
            bus.full         <= (count_nxt_c == CW'(DEPTH));
            bus.empty        <= (count_nxt_c == CW'(0));
            bus.almost_full  <= (count_nxt_c >= CW'(ALMOST_FULL_THRESH));
            bus.almost_empty <= (count_nxt_c <= CW'(ALMOST_EMPTY_THRESH));
        end
    end
endmodule
